// File: rtl/serial_frame_serializer.sv
// Parallel-to-serial frame serializer feeding a downstream sequence detector.
// Optional trailing even-parity bit is compiled in with `define SER_PARITY_EN.
module serial_frame_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dataout,
    output logic             dataout_valid,
    output logic             busy
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;
    logic             final_cycle;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             parity;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // NOTE: load_ready is gated by reset directly so no word can be accepted
    // while reset is held, even though state is only updated at the edge.
    always_comb begin
`ifdef SER_PARITY_EN
        final_cycle = (state == PAR);
`else
        final_cycle = (state == SHIFT) && (count == LAST);
`endif
        load_ready = reset && ((state == IDLE) || final_cycle);
    end

    assign accept = load_valid && load_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            shreg         <= '0;
            dataout       <= 1'b0;
            dataout_valid <= 1'b0;
`ifdef SER_PARITY_EN
            parity        <= 1'b0;
`endif
        end else begin
            // NOTE: outputs default to 0 each cycle; branches below only
            // override them when a frame bit is being presented.
            dataout       <= 1'b0;
            dataout_valid <= 1'b0;
            if (accept) begin
                state         <= SHIFT;
                count         <= '0;
                shreg         <= advance(load_data);
                dataout       <= head(load_data);
                dataout_valid <= 1'b1;
`ifdef SER_PARITY_EN
                parity        <= ^load_data;
`endif
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    SHIFT: begin
                        if (count == LAST) begin
                            count <= '0;
`ifdef SER_PARITY_EN
                            state         <= PAR;
                            dataout       <= parity;
                            dataout_valid <= 1'b1;
`else
                            state <= IDLE;
`endif
                        end else begin
                            count         <= count + 1'b1;
                            shreg         <= advance(shreg);
                            dataout       <= head(shreg);
                            dataout_valid <= 1'b1;
                        end
                    end
`ifdef SER_PARITY_EN
                    PAR: state <= IDLE;
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/serial_frame_serializer.md
SERIAL_FRAME_SERIALIZER -- requirements
Module: serial_frame_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of data bits per word (legal 2..32).
REQ-002 SHALL provide parameter MSB_FIRST, default 1, where 1 means bit WIDTH-1 is sent first and 0 means bit 0 is sent first.
REQ-003 SHALL provide port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port load_data  input  WIDTH  parallel word to serialize.
REQ-006 SHALL provide port load_valid  input  1  load_data is valid this cycle.
REQ-007 SHALL provide port load_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL provide port dataout  output  1  serial bit stream to the downstream sequence detector's datain.
REQ-009 SHALL provide port dataout_valid  output  1  dataout carries a frame bit this cycle.
REQ-010 SHALL provide port busy  output  1  a frame is in progress (state not IDLE).

Function
REQ-011 SHALL accept a word on a rising edge where load_valid=1 and load_ready=1; no other condition captures load_data.
REQ-012 SHALL implement FSM states IDLE, SHIFT, PAR (PAR reachable only with the parity feature compiled in).
REQ-013 SHALL transition IDLE->SHIFT on accept, and otherwise hold IDLE.
REQ-014 SHALL, in SHIFT, keep a bit counter 0..WIDTH-1 that increments each cycle; at count WIDTH-1 it goes to PAR (parity on), or on a new accept to SHIFT with count 0, or otherwise to IDLE.
REQ-015 SHALL go PAR->SHIFT (count 0) on a new accept, else PAR->IDLE.
REQ-016 SHALL drive load_ready combinationally high in IDLE and in the final frame cycle (SHIFT at count WIDTH-1 without parity; PAR with parity), and low otherwise.
REQ-017 SHALL register dataout and dataout_valid; the first bit appears the cycle after accept (latency 1) and the bits are contiguous, one per cycle, in MSB_FIRST order.
REQ-018 SHALL support back-to-back words with zero idle cycles between frames when accepted in the final frame cycle.
REQ-019 SHALL drive dataout=0 and dataout_valid=0 in every cycle with no frame bit.
REQ-020 SHALL ignore load_valid and load_data while load_ready=0; the word in flight is unaffected.
REQ-021 SHALL leave an asserted load_valid that is not accepted pending; the block neither drops nor duplicates words.

Reset
REQ-022 SHALL, while reset=0 at a rising edge, set the state to IDLE, the counter, shift register, dataout and dataout_valid to 0, and busy to 0.
REQ-023 SHALL, when reset asserts mid-frame, abort the frame; no remaining bits of that word are ever emitted.
REQ-024 SHALL hold load_ready=0 while reset=0, and accept is first possible on the first edge after reset returns to 1.

Configuration
REQ-025 SHALL compile a trailing even-parity bit in when macro SER_PARITY_EN is defined: PAR emits the XOR of the WIDTH data bits with dataout_valid=1, so the frame is WIDTH+1 cycles.
REQ-026 SHALL, without SER_PARITY_EN, have no PAR state and no parity logic, and the frame is exactly WIDTH cycles.

Verification
REQ-027 SHALL cover: after reset, accept 8'hE8 with MSB_FIRST=1 -> dataout 1,1,1,0,1,0,0,0 on cycles 1..8 with dataout_valid=1, then IDLE with dataout_valid=0.
REQ-028 SHALL cover: 8'hE8 then 8'h0F held valid continuously -> 16 contiguous valid bits 11101000 00001111, and load_ready high only in IDLE and in cycle 8.
REQ-029 SHALL cover: with SER_PARITY_EN, accept 8'h07 -> bits 00000111 then parity bit 1 (9 valid cycles); accept 8'h03 -> parity bit 0.
REQ-030 SHALL cover: MSB_FIRST=0 and 8'h17 -> dataout 1,1,1,0,1,0,0,0.
REQ-031 SHALL cover: reset=0 in cycle 3 of a frame -> dataout_valid=0 and busy=0 from the next cycle, no residual bits, and the next accepted word is serialized intact.
REQ-032 SHALL cover: load_valid pulsed with 8'hFF while busy and load_ready=0 -> 8'hFF never appears on dataout and the current frame is unchanged.
